// File: rtl/smalldiv_pkg.sv
// Shared types and elaboration-time helpers for the radix converter and its divider.
package smalldiv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        EMIT   = 2'd2
    } state_e;

    // Number of divisions by radix that reduce the largest width-bit value to zero.
    function automatic int max_digits(input int radix, input int width);
        longint unsigned v;
        longint unsigned r;
        int              n;
        v = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
        r = 64'(radix);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (v != 64'd0) begin
                v = v / r;
                n = n + 1;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/smalldiv.sv
// Divide-by-constant unit with optional input/output register stages.
module smalldiv #(
    parameter  int DIVIDER_VALUE  = 10,
    parameter  int DIVIDEND_WIDTH = 18,
    parameter  int REGISTER_IN    = 0,
    parameter  int REGISTER_OUT   = 0,
    localparam int REM_WIDTH      = (DIVIDER_VALUE > 1) ? $clog2(DIVIDER_VALUE) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable_i,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
    output logic [DIVIDEND_WIDTH-1:0] quotient_o,
    output logic [REM_WIDTH-1:0]      remainder_o
);

    localparam logic [DIVIDEND_WIDTH-1:0] DIVISOR = DIVIDEND_WIDTH'(DIVIDER_VALUE);

    logic [DIVIDEND_WIDTH-1:0] dvd;
    logic [DIVIDEND_WIDTH-1:0] quo;
    logic [DIVIDEND_WIDTH-1:0] rem_full;

    generate
        if (REGISTER_IN != 0) begin : g_reg_in
            logic [DIVIDEND_WIDTH-1:0] dvd_q;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)      dvd_q <= '0;
                else if (enable_i) dvd_q <= dividend_i;
            end
            assign dvd = dvd_q;
        end else begin : g_comb_in
            assign dvd = dividend_i;
        end
    endgenerate

    // Constant divisor lets synthesis reduce these to multiply/shift networks.
    assign quo      = dvd / DIVISOR;
    assign rem_full = dvd % DIVISOR;

    generate
        if (REGISTER_OUT != 0) begin : g_reg_out
            logic [DIVIDEND_WIDTH-1:0] quo_q;
            logic [REM_WIDTH-1:0]      rem_q;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    quo_q <= '0;
                    rem_q <= '0;
                end else if (enable_i) begin
                    quo_q <= quo;
                    rem_q <= REM_WIDTH'(rem_full);
                end
            end
            assign quotient_o  = quo_q;
            assign remainder_o = rem_q;
        end else begin : g_comb_out
            assign quotient_o  = quo;
            assign remainder_o = REM_WIDTH'(rem_full);
        end
    endgenerate

    // Clock/reset/enable are only consumed by the optional register stages.
    logic unused_ok;
    assign unused_ok = &{1'b0, clock, reset_n, enable_i};

endmodule

// File: rtl/smalldiv_radix_conv.sv
// Serial radix converter: emits the digits of a value LSD-first, one per DIVIDE/EMIT pair.
// SMALLDIV_RADIX_CONV_FIXED_LEN_EN: emit exactly MAX_DIGITS zero-padded digits per value.
module smalldiv_radix_conv
    import smalldiv_pkg::*;
#(
    parameter  int RADIX       = 10,
    parameter  int VALUE_WIDTH = 18,
    parameter  int DIGIT_WIDTH = $clog2(RADIX),
    localparam int MAX_DIGITS  = max_digits(RADIX, VALUE_WIDTH),
    localparam int INDEX_WIDTH = index_width(MAX_DIGITS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VALUE_WIDTH-1:0] in_value,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIGIT_WIDTH-1:0] out_digit,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic                   out_last
);

    localparam int REM_WIDTH = (RADIX > 1) ? $clog2(RADIX) : 1;
    localparam logic [INDEX_WIDTH-1:0] MAX_IDX = INDEX_WIDTH'(MAX_DIGITS - 1);

    state_e                 state_q, state_d;
    logic [VALUE_WIDTH-1:0] work_q, work_d;
    logic [DIGIT_WIDTH-1:0] digit_q, digit_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic                   last_q, last_d;

    logic [VALUE_WIDTH-1:0] quotient;
    logic [REM_WIDTH-1:0]   remainder;

    smalldiv #(
        .DIVIDER_VALUE (RADIX),
        .DIVIDEND_WIDTH(VALUE_WIDTH),
        .REGISTER_IN   (0),
        .REGISTER_OUT  (0)
    ) u_div (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable_i   (1'b1),
        .dividend_i (work_q),
        .quotient_o (quotient),
        .remainder_o(remainder)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            digit_q <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            digit_q <= digit_d;
            index_q <= index_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        digit_d = digit_q;
        index_d = index_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_value;
                    index_d = '0;
                    digit_d = '0;
                    last_d  = 1'b0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                digit_d = DIGIT_WIDTH'(remainder);
                work_d  = quotient;
`ifdef SMALLDIV_RADIX_CONV_FIXED_LEN_EN
                last_d  = (index_q == MAX_IDX);
`else
                // The index term is a backstop; the quotient always reaches zero by then.
                last_d  = (quotient == '0) || (index_q == MAX_IDX);
`endif
                state_d = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + INDEX_WIDTH'(1);
                        state_d = DIVIDE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All outputs come straight from state/registers; out_ready only affects next state.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_digit = digit_q;
    assign out_index = index_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_smalldiv_radix_conv.sv
// Randomized self-checking bench for smalldiv_radix_conv (radix 10 and radix 8 instances).
module tb_smalldiv_radix_conv;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic [17:0] in_value;
    logic        out_ready;
    logic        sel;

    logic       in_ready_a, out_valid_a, out_last_a;
    logic [3:0] out_digit_a;
    logic [2:0] out_index_a;
    logic       in_ready_b, out_valid_b, out_last_b;
    logic [2:0] out_digit_b;
    logic [2:0] out_index_b;

    wire in_valid_a = in_valid & ~sel;
    wire in_valid_b = in_valid & sel;

    wire       in_ready_m  = sel ? in_ready_b  : in_ready_a;
    wire       out_valid_m = sel ? out_valid_b : out_valid_a;
    wire       last_m      = sel ? out_last_b  : out_last_a;
    wire [3:0] digit_m     = sel ? {1'b0, out_digit_b} : out_digit_a;
    wire [2:0] index_m     = sel ? out_index_b : out_index_a;

    int vectors = 0;
    int errors  = 0;
    int unsigned exp_q[$];

    smalldiv_radix_conv #(.RADIX(10), .VALUE_WIDTH(18)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_value(in_value),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_digit(out_digit_a), .out_index(out_index_a), .out_last(out_last_a)
    );

    smalldiv_radix_conv #(.RADIX(8), .VALUE_WIDTH(18)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_value(in_value),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_digit(out_digit_b), .out_index(out_index_b), .out_last(out_last_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Reference: repeated division, least significant digit first (6 digits max for 18 bits).
    task automatic build_expected(input int unsigned value, input int unsigned radix);
        int unsigned v;
        v = value;
        exp_q.delete();
`ifdef SMALLDIV_RADIX_CONV_FIXED_LEN_EN
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(v % radix);
            v = v / radix;
        end
`else
        do begin
            exp_q.push_back(v % radix);
            v = v / radix;
        end while (v != 0);
`endif
    endtask

    task automatic run_conv(input int unsigned value, input int stall_idx,
                            input bit rand_ready, input bit pulse_busy);
        int idx, stalls, cyc;
        int unsigned radix;
        logic [3:0] e_dig;
        logic [2:0] e_idx;
        logic       e_last;
        radix = sel ? 8 : 10;
        build_expected(value, radix);
        out_ready = 1'b0;
        cyc = 0;
        while (!in_ready_m && cyc < 20) begin step(); cyc++; end
        vectors++;
        if (in_ready_m !== 1'b1) begin
            errors++; $display("FAIL ready_wait value=%0d got in_ready=%b want 1", value, in_ready_m);
        end
        in_valid = 1'b1;
        in_value = 18'(value);
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid_m !== 1'b0 || in_ready_m !== 1'b0) begin
            errors++; $display("FAIL latency_divide value=%0d got out_valid=%b in_ready=%b want 0 0",
                               value, out_valid_m, in_ready_m);
        end
        step();
        vectors++;
        if (out_valid_m !== 1'b1) begin
            errors++; $display("FAIL latency_emit value=%0d got out_valid=%b want 1", value, out_valid_m);
        end
        idx = 0; stalls = 0; cyc = 0;
        while (idx < exp_q.size() && cyc < 300) begin
            if (pulse_busy) begin
                in_valid = 1'($urandom_range(0, 1));
                in_value = 18'd777;
            end
            if (stall_idx == idx && stalls < 3 && out_valid_m) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            vectors++;
            if (in_ready_m !== 1'b0) begin
                errors++; $display("FAIL busy_ready value=%0d got in_ready=%b want 0", value, in_ready_m);
            end
            if (out_valid_m) begin
                e_dig  = 4'(exp_q[idx]);
                e_idx  = 3'(idx);
                e_last = (idx == exp_q.size() - 1);
                vectors++;
                if (digit_m !== e_dig || index_m !== e_idx || last_m !== e_last) begin
                    errors++;
                    $display("FAIL digit value=%0d got d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                             value, digit_m, index_m, last_m, e_dig, e_idx, e_last);
                end
            end
            if (out_valid_m && out_ready) idx++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (idx != exp_q.size()) begin
            errors++; $display("FAIL digit_count value=%0d got %0d want %0d", value, idx, exp_q.size());
        end
        vectors++;
        if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
            errors++; $display("FAIL back_to_idle value=%0d got in_ready=%b out_valid=%b want 1 0",
                               value, in_ready_m, out_valid_m);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if (out_valid_m !== 1'b0) begin
                errors++; $display("FAIL no_extra_digit value=%0d got out_valid=%b want 0", value, out_valid_m);
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; in_value = '0; out_ready = 1'b0; sel = 1'b0;
        step(); step();
        vectors++;
        if ({out_valid_a, out_digit_a, out_index_a, out_last_a} !== 9'd0 ||
            {out_valid_b, out_digit_b, out_index_b, out_last_b} !== 8'd0) begin
            errors++; $display("FAIL reset_outputs got a=%b%h%h%b b=%b%h%h%b want all 0",
                out_valid_a, out_digit_a, out_index_a, out_last_a,
                out_valid_b, out_digit_b, out_index_b, out_last_b);
        end
        reset_n = 1'b1;
        step();
        vectors++;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1 || out_valid_a !== 1'b0) begin
            errors++; $display("FAIL reset_release got in_ready=%b%b out_valid=%b want 11 0",
                               in_ready_a, in_ready_b, out_valid_a);
        end
    endtask

    task automatic test_basic;
        sel = 1'b0;
        run_conv(12345, -1, 1'b0, 1'b0);
        run_conv(0, -1, 1'b0, 1'b0);
        run_conv(262143, -1, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        sel = 1'b0;
        run_conv(12345, 2, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore;
        sel = 1'b0;
        run_conv(12345, -1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid;
        int cnt, cyc;
        sel = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_value = 18'd12345;
        step();
        in_valid = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 2 && cyc < 20) begin
            if (out_valid_m) cnt++;
            step(); cyc++;
        end
        cyc = 0;
        while (!out_valid_m && cyc < 20) begin step(); cyc++; end
        vectors++;
        if (out_valid_m !== 1'b1 || index_m !== 3'd2) begin
            errors++; $display("FAIL reset_mid_setup got out_valid=%b index=%0d want 1 2", out_valid_m, index_m);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid_m !== 1'b0 || digit_m !== 4'd0 || index_m !== 3'd0 || last_m !== 1'b0) begin
            errors++; $display("FAIL reset_mid_async got v=%b d=%0d i=%0d l=%b want 0 0 0 0",
                               out_valid_m, digit_m, index_m, last_m);
        end
        step(); step();
        reset_n = 1'b1;
        step();
        vectors++;
        if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
            errors++; $display("FAIL reset_mid_release got out_valid=%b in_ready=%b want 0 1", out_valid_m, in_ready_m);
        end
        run_conv(9, -1, 1'b0, 1'b0);
    endtask

    task automatic test_len_and_radix8;
        sel = 1'b0;
        run_conv(42, -1, 1'b0, 1'b0);
        sel = 1'b1;
        run_conv(15, -1, 1'b0, 1'b0);
        sel = 1'b0;
    endtask

    task automatic test_random;
        int unsigned v;
        for (int n = 0; n < 24; n++) begin
            sel = 1'($urandom_range(0, 1));
            v = (n % 3 == 0) ? $urandom_range(0, 99) : $urandom_range(0, 262143);
            run_conv(v, -1, 1'b1, 1'($urandom_range(0, 1)));
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_busy_ignore();
        test_reset_mid();
        test_len_and_radix8();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/smalldiv_radix_conv.md
SMALLDIV_RADIX_CONV -- requirements
Module: smalldiv_radix_conv

Interface
REQ-001 The block SHALL have parameter RADIX, default 10, constant divisor and output digit base (>= 2).
REQ-002 The block SHALL have parameter VALUE_WIDTH, default 18, input value width.
REQ-003 The block SHALL have derived parameter DIGIT_WIDTH, default $clog2(RADIX), digit and remainder width.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all logic SHALL be rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, value offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit, block can accept a value.
REQ-008 The block SHALL have port in_value, input, VALUE_WIDTH bits, unsigned value to convert.
REQ-009 The block SHALL have port out_valid, output, 1 bit, digit presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit, consumer accepts digit.
REQ-011 The block SHALL have port out_digit, output, DIGIT_WIDTH bits, digit value 0..RADIX-1.
REQ-012 The block SHALL have port out_index, output, INDEX_WIDTH bits, digit position with 0 = least significant.
REQ-013 The block SHALL have port out_last, output, 1 bit, marks the final digit of the current value.

Function
REQ-014 The block SHALL use MAX_DIGITS, the count of divisions by RADIX that reduce 2^VALUE_WIDTH-1 to zero (6 for the defaults); INDEX_WIDTH SHALL be max(1, $clog2(MAX_DIGITS)).
REQ-015 The FSM SHALL have exactly three states: IDLE, DIVIDE and EMIT.
REQ-016 In IDLE, in_ready SHALL be 1, and in_valid&in_ready SHALL load in_value into the work register, clear the index and go to DIVIDE.
REQ-017 In DIVIDE (1 cycle), the combinational divider outputs SHALL be latched: remainder into the digit register, quotient into the work register, last flag = (quotient == 0); the FSM SHALL then go to EMIT.
REQ-018 In EMIT, out_valid SHALL be 1; out_digit, out_index and out_last SHALL hold stable until out_valid&out_ready.
REQ-019 On an EMIT handshake with out_last=1, the FSM SHALL go to IDLE.
REQ-020 On an EMIT handshake with out_last=0, the index SHALL increment and the FSM SHALL go to DIVIDE.
REQ-021 Digits SHALL be emitted least significant first, with 2 cycles per digit minimum; the first out_valid SHALL occur 2 cycles after input acceptance.
REQ-022 in_value = 0 SHALL produce exactly one digit: 0, index 0, out_last=1.
REQ-023 in_ready SHALL be 0 outside IDLE; in_valid asserted while busy SHALL be ignored and not queued.
REQ-024 The block SHALL NOT produce a handshake-dependent combinational path from out_ready to any output.
REQ-025 out_index SHALL NOT exceed MAX_DIGITS-1.

Reset
REQ-026 Asserting reset_n low SHALL immediately force IDLE, and the values SHALL be in_ready=1 after release, out_valid=0, out_digit=0, out_index=0, out_last=0, work=0.
REQ-027 Reset mid-conversion SHALL discard the conversion with no further digits.
REQ-028 Release SHALL be synchronous to clock.

Configuration
REQ-029 Macro SMALLDIV_RADIX_CONV_FIXED_LEN_EN, when defined, SHALL emit exactly MAX_DIGITS digits per value, zero-padded in the upper positions, with out_last set only at index MAX_DIGITS-1.
REQ-030 When the macro is undefined, emission SHALL stop at the first zero quotient per REQ-017.

Structure
REQ-031 Package smalldiv_pkg SHALL hold the state enum (IDLE, DIVIDE, EMIT) and the constant function computing MAX_DIGITS from RADIX and VALUE_WIDTH.
REQ-032 The block SHALL instantiate one smalldiv sub-module with DIVIDER_VALUE=RADIX, DIVIDEND_WIDTH=VALUE_WIDTH, REGISTER_IN=0, REGISTER_OUT=0 and enable tied 1, with dividend driven from the work register.

Verification
REQ-033 The bench SHALL cover: 12345, RADIX 10 -> digits 5,4,3,2,1 at index 0..4, out_last only on 1.
REQ-034 The bench SHALL cover: 0 -> single digit 0, index 0, out_last=1; 262143 -> 3,4,1,2,6,2, last at index 5.
REQ-035 The bench SHALL cover: out_ready low 3 cycles during digit 2 of 12345 -> out_digit=3, out_index=2 held stable; no digit lost or duplicated.
REQ-036 The bench SHALL cover: in_valid with value 777 pulsed during an active conversion -> in_ready=0, 777 never emitted.
REQ-037 The bench SHALL cover: reset_n low after second digit -> out_valid=0 same cycle; next value 9 -> single digit 9 last.
REQ-038 The bench SHALL cover, with SMALLDIV_RADIX_CONV_FIXED_LEN_EN defined: 42 -> 2,4,0,0,0,0, out_last at index 5; and RADIX 8 with 0o17 -> 7,1 (macro undefined).
